hazard_unit_mc: RTL and testbench
=================================

HAZARD_UNIT_MC -- requirements
Module: hazard_unit_mc

Interface
REQ-001 Parameters SHALL be, one per line, as name, default, meaning:
  - REG_W, 4, register-address width.
  - MC_LAT, 4, multicycle execute latency in cycles, 2..16.
  - CNT_W, 16, stall-counter width.
  - R0_HARDWIRED, 0, if 1 then address 0 never forwards or stalls.
REQ-002 Ports SHALL be, one per line, as name, direction, width, meaning:
  - clk  in  1  single clock, rising edge.
  - Reset  in  1  asynchronous, active-low reset.
  - RegWriteM, RegWriteW, MemToRegE  in  1 each  pipeline write controls.
  - BranchTakenE  in  1  branch resolved taken in E.
  - PCSrcD, PCSrcE, PCSrcM, PCSrcW  in  1 each  PC-write instruction in that stage.
  - McStartE  in  1  multicycle op (MUL/DIV) present in E.
  - RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W  in  REG_W each  register addresses.
  - StallF, StallD, StallE  out  1 each  hold stage register.
  - FlushD, FlushE, FlushM  out  1 each  bubble stage register.
  - ForwardAE, ForwardBE  out  2 each  operand source select.
  - McBusy  out  1  multicycle FSM not idle.
  - StallCnt  out  CNT_W  saturating count of cycles with StallF=1.

Function
REQ-003 ForwardXE SHALL be 2'b10 if RAxE==WA3M and RegWriteM, else 2'b01 if RAxE==WA3W and RegWriteW, else 2'b00; M has priority over W.
REQ-004 With R0_HARDWIRED=1, a source or destination address of 0 SHALL force ForwardXE=2'b00 and SHALL NOT raise LdStall.
REQ-005 LdStall SHALL be MemToRegE and (RA1D==WA3E or RA2D==WA3E).
REQ-006 PCWrPending SHALL be PCSrcD or PCSrcE or PCSrcM.
REQ-007 In RUN: StallD=LdStall; StallF=LdStall|PCWrPending; FlushE=LdStall|BranchTakenE; FlushD=PCWrPending|PCSrcW|BranchTakenE; StallE=FlushM=0.
REQ-008 The FSM SHALL have states RUN and MC_BUSY, with a down-counter of width clog2(MC_LAT).
REQ-009 RUN->MC_BUSY SHALL occur at the edge where McStartE=1 and BranchTakenE=0, loading the counter with MC_LAT-2.
REQ-010 In MC_BUSY, StallF=StallD=StallE=1, FlushM=1 and FlushE=FlushD=0, regardless of LdStall or PCWrPending; the counter SHALL decrement each cycle.
REQ-011 MC_BUSY->RUN SHALL occur when the counter is 0, so the op holds E for exactly MC_LAT cycles; REQ-007 outputs SHALL resume the next cycle.
REQ-012 McStartE SHALL be ignored while in MC_BUSY and when BranchTakenE=1 (branch wins).
REQ-013 McBusy SHALL be 1 iff state is MC_BUSY.
REQ-014 StallCnt SHALL increment on each edge with StallF=1 and saturate at all-ones with no wrap.
REQ-015 All stall, flush and forward outputs SHALL be combinational from inputs and registered state, with zero-cycle latency.

Reset
REQ-016 Reset=0 SHALL asynchronously force state RUN, counter 0 and StallCnt 0.
REQ-017 While Reset=0, all stall and flush outputs and McBusy SHALL be 0; forwarding SHALL remain functional.
REQ-018 Reset asserted mid-MC_BUSY SHALL abort the op with no residual stall after release.

Configuration
REQ-019 Macro HAZARD_MC_EN defined SHALL build the multicycle FSM and counter per REQ-008..REQ-013.
REQ-020 With HAZARD_MC_EN undefined, there SHALL be no FSM or counter registers; McStartE SHALL be ignored; StallE, FlushM and McBusy SHALL be constant 0; REQ-007 SHALL always apply.

Structure
REQ-021 Package hazard_pkg SHALL hold the state enum (RUN, MC_BUSY) and forward constants FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
REQ-022 Sub-module hazard_fwd_sel SHALL compute one operand's forward select and be instantiated twice (A, B).

Verification
REQ-023 Scenario: RA1E=3, WA3M=3, WA3W=3, RegWriteM=RegWriteW=1 -> ForwardAE=2'b10; with RegWriteM=0 -> ForwardAE=2'b01.
REQ-024 Scenario: MemToRegE=1, WA3E=5, RA2D=5 -> StallF=StallD=FlushE=1 for one cycle; with R0_HARDWIRED=1 and WA3E=RA2D=0 -> no stall.
REQ-025 Scenario: MC_LAT=4, McStartE pulse -> McBusy and StallE high for 3 cycles after the start edge; FlushM high the same cycles; RUN on the 4th.
REQ-026 Scenario: McStartE=1 with BranchTakenE=1 -> no MC_BUSY; FlushD=FlushE=1.
REQ-027 Scenario: Reset low during the 2nd MC_BUSY cycle -> McBusy=0 immediately, StallCnt=0, no stall after release.
REQ-028 Scenario: CNT_W=4 with StallF held high for 20 cycles -> StallCnt=4'hF, no wrap.

Source files
------------

// File: rtl/hazard_pkg.sv
// ============================================================================
//  Module   : hazard_pkg
//  Brief    : Shared types and forward-select encodings for the hazard unit.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package hazard_pkg;

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        MC_BUSY = 1'b1
    } mc_state_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

`default_nettype wire

// File: rtl/hazard_fwd_sel.sv
// ============================================================================
//  Module   : hazard_fwd_sel
//  Brief    : Forward-source select for one execute-stage operand.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module hazard_fwd_sel
    import hazard_pkg::*;
#(
    parameter int REG_W        = 4,
    parameter int R0_HARDWIRED = 0
) (
    input  logic [REG_W-1:0] i_ra_e,
    input  logic [REG_W-1:0] i_wa3_m,
    input  logic [REG_W-1:0] i_wa3_w,
    input  logic             i_reg_write_m,
    input  logic             i_reg_write_w,
    output logic [1:0]       o_fwd
);

    logic w_src_zero;

    // A match against address 0 implies both sides are 0, so the source test suffices.
    assign w_src_zero = (R0_HARDWIRED != 0) && (i_ra_e == '0);

    always_comb begin
        o_fwd = FWD_RF;
        if (!w_src_zero) begin
            if (i_reg_write_m && (i_ra_e == i_wa3_m)) begin
                o_fwd = FWD_MEM;
            end else if (i_reg_write_w && (i_ra_e == i_wa3_w)) begin
                o_fwd = FWD_WB;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/hazard_unit_mc.sv
// ============================================================================
//  Module   : hazard_unit_mc
//  Brief    : Pipeline hazard unit with forwarding, load-use / PC-write stalls
//             and an optional multicycle-execute hold (macro HAZARD_MC_EN).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module hazard_unit_mc
    import hazard_pkg::*;
#(
    parameter int REG_W        = 4,
    parameter int MC_LAT       = 4,
    parameter int CNT_W        = 16,
    parameter int R0_HARDWIRED = 0
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             MemToRegE,
    input  logic             BranchTakenE,
    input  logic             PCSrcD,
    input  logic             PCSrcE,
    input  logic             PCSrcM,
    input  logic             PCSrcW,
    input  logic             McStartE,
    input  logic [REG_W-1:0] RA1D,
    input  logic [REG_W-1:0] RA2D,
    input  logic [REG_W-1:0] RA1E,
    input  logic [REG_W-1:0] RA2E,
    input  logic [REG_W-1:0] WA3E,
    input  logic [REG_W-1:0] WA3M,
    input  logic [REG_W-1:0] WA3W,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushM,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             McBusy,
    output logic [CNT_W-1:0] StallCnt
);

    logic             w_ld_stall;
    logic             w_pc_pending;
    logic             w_busy;
    logic [CNT_W-1:0] r_stall_cnt;

    hazard_fwd_sel #(.REG_W(REG_W), .R0_HARDWIRED(R0_HARDWIRED)) u_fwd_a (
        .i_ra_e        (RA1E),
        .i_wa3_m       (WA3M),
        .i_wa3_w       (WA3W),
        .i_reg_write_m (RegWriteM),
        .i_reg_write_w (RegWriteW),
        .o_fwd         (ForwardAE)
    );

    hazard_fwd_sel #(.REG_W(REG_W), .R0_HARDWIRED(R0_HARDWIRED)) u_fwd_b (
        .i_ra_e        (RA2E),
        .i_wa3_m       (WA3M),
        .i_wa3_w       (WA3W),
        .i_reg_write_m (RegWriteM),
        .i_reg_write_w (RegWriteW),
        .o_fwd         (ForwardBE)
    );

    assign w_ld_stall   = MemToRegE && ((RA1D == WA3E) || (RA2D == WA3E)) &&
                          !((R0_HARDWIRED != 0) && (WA3E == '0));
    assign w_pc_pending = PCSrcD || PCSrcE || PCSrcM;

`ifdef HAZARD_MC_EN
    localparam int                  c_MC_CW   = $clog2(MC_LAT);
    localparam logic [c_MC_CW-1:0]  c_MC_LOAD = c_MC_CW'(MC_LAT - 2);

    mc_state_t          r_state;
    mc_state_t          w_state_nxt;
    logic [c_MC_CW-1:0] r_mc_cnt;
    logic [c_MC_CW-1:0] w_mc_cnt_nxt;

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            r_state  <= RUN;
            r_mc_cnt <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_mc_cnt <= w_mc_cnt_nxt;
        end
    end

    // The start cycle itself plus MC_LAT-1 busy cycles hold the op in E for MC_LAT cycles.
    always_comb begin
        w_state_nxt  = r_state;
        w_mc_cnt_nxt = r_mc_cnt;
        case (r_state)
            RUN: begin
                if (McStartE && !BranchTakenE) begin
                    w_state_nxt  = MC_BUSY;
                    w_mc_cnt_nxt = c_MC_LOAD;
                end
            end
            MC_BUSY: begin
                if (r_mc_cnt == '0) begin
                    w_state_nxt = RUN;
                end else begin
                    w_mc_cnt_nxt = r_mc_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt  = RUN;
                w_mc_cnt_nxt = '0;
            end
        endcase
    end

    assign w_busy = (r_state == MC_BUSY);
`else
    logic w_unused_mc;

    assign w_unused_mc = McStartE;
    assign w_busy      = 1'b0;
`endif

    // Reset gates every stall/flush output; forwarding stays live.
    assign StallF = Reset && (w_busy || w_ld_stall || w_pc_pending);
    assign StallD = Reset && (w_busy || w_ld_stall);
    assign StallE = Reset && w_busy;
    assign FlushM = Reset && w_busy;
    assign FlushE = Reset && !w_busy && (w_ld_stall || BranchTakenE);
    assign FlushD = Reset && !w_busy && (w_pc_pending || PCSrcW || BranchTakenE);
    assign McBusy = Reset && w_busy;

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            r_stall_cnt <= '0;
        end else if (StallF && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign StallCnt = r_stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_hazard_unit_mc.sv
// ============================================================================
//  Module   : tb_hazard_unit_mc
//  Brief    : Directed-vector bench for hazard_unit_mc (default and R0/CNT_W=4 instances).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_hazard_unit_mc;

    logic       clk = 1'b0;
    logic       Reset;
    logic       RegWriteM, RegWriteW, MemToRegE, BranchTakenE;
    logic       PCSrcD, PCSrcE, PCSrcM, PCSrcW, McStartE;
    logic [3:0] RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;

    logic        StallF, StallD, StallE, FlushD, FlushE, FlushM, McBusy;
    logic [1:0]  ForwardAE, ForwardBE;
    logic [15:0] StallCnt;

    logic        StallF_2, StallD_2, StallE_2, FlushD_2, FlushE_2, FlushM_2, McBusy_2;
    logic [1:0]  ForwardAE_2, ForwardBE_2;
    logic [3:0]  StallCnt_2;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hazard_unit_mc dut (
        .clk(clk), .Reset(Reset),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemToRegE(MemToRegE),
        .BranchTakenE(BranchTakenE),
        .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM), .PCSrcW(PCSrcW),
        .McStartE(McStartE),
        .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
        .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
        .StallF(StallF), .StallD(StallD), .StallE(StallE),
        .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .McBusy(McBusy), .StallCnt(StallCnt)
    );

    hazard_unit_mc #(.CNT_W(4), .R0_HARDWIRED(1)) dut2 (
        .clk(clk), .Reset(Reset),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemToRegE(MemToRegE),
        .BranchTakenE(BranchTakenE),
        .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM), .PCSrcW(PCSrcW),
        .McStartE(McStartE),
        .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
        .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
        .StallF(StallF_2), .StallD(StallD_2), .StallE(StallE_2),
        .FlushD(FlushD_2), .FlushE(FlushE_2), .FlushM(FlushM_2),
        .ForwardAE(ForwardAE_2), .ForwardBE(ForwardBE_2),
        .McBusy(McBusy_2), .StallCnt(StallCnt_2)
    );

    typedef struct {
        logic       rwm, rww, m2r, bt, pcd, pce, pcm, pcw;
        logic [3:0] ra1d, ra2d, ra1e, ra2e, wa3e, wa3m, wa3w;
        logic       sf, sd, fd, fe;
        logic [1:0] fa, fb;
    } vec_t;

    localparam int NV = 15;
    vec_t tbl [NV];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic clear_inputs();
        RegWriteM = 0; RegWriteW = 0; MemToRegE = 0; BranchTakenE = 0;
        PCSrcD = 0; PCSrcE = 0; PCSrcM = 0; PCSrcW = 0; McStartE = 0;
        RA1D = 4'd1; RA2D = 4'd2; RA1E = 4'd3; RA2E = 4'd4;
        WA3E = 4'd5; WA3M = 4'd6; WA3W = 4'd7;
    endtask

    task automatic do_reset();
        @(negedge clk); Reset = 0;
        @(negedge clk); Reset = 1;
    endtask

    initial begin
        //          rwm rww m2r bt pcd pce pcm pcw ra1d ra2d ra1e ra2e wa3e wa3m wa3w sf sd fd fe fa     fb
        tbl[0]  = '{0,  0,  0,  0, 0,  0,  0,  0,  1,   2,   3,   4,   5,   6,   7,   0, 0, 0, 0, 2'b00, 2'b00};
        tbl[1]  = '{1,  1,  0,  0, 0,  0,  0,  0,  1,   2,   3,   7,   9,   3,   3,   0, 0, 0, 0, 2'b10, 2'b00};
        tbl[2]  = '{0,  1,  0,  0, 0,  0,  0,  0,  1,   2,   3,   7,   9,   3,   3,   0, 0, 0, 0, 2'b01, 2'b00};
        tbl[3]  = '{1,  1,  0,  0, 0,  0,  0,  0,  1,   2,   6,   6,   9,   6,   6,   0, 0, 0, 0, 2'b10, 2'b10};
        tbl[4]  = '{1,  1,  0,  0, 0,  0,  0,  0,  1,   2,   2,   4,   9,   4,   2,   0, 0, 0, 0, 2'b01, 2'b10};
        tbl[5]  = '{0,  0,  1,  0, 0,  0,  0,  0,  1,   5,   3,   4,   5,   6,   7,   1, 1, 0, 1, 2'b00, 2'b00};
        tbl[6]  = '{0,  0,  1,  0, 0,  0,  0,  0,  5,   2,   3,   4,   5,   6,   7,   1, 1, 0, 1, 2'b00, 2'b00};
        tbl[7]  = '{0,  0,  0,  0, 0,  0,  0,  0,  1,   5,   3,   4,   5,   6,   7,   0, 0, 0, 0, 2'b00, 2'b00};
        tbl[8]  = '{0,  0,  0,  0, 1,  0,  0,  0,  1,   2,   3,   4,   5,   6,   7,   1, 0, 1, 0, 2'b00, 2'b00};
        tbl[9]  = '{0,  0,  0,  0, 0,  1,  0,  0,  1,   2,   3,   4,   5,   6,   7,   1, 0, 1, 0, 2'b00, 2'b00};
        tbl[10] = '{0,  0,  0,  0, 0,  0,  1,  0,  1,   2,   3,   4,   5,   6,   7,   1, 0, 1, 0, 2'b00, 2'b00};
        tbl[11] = '{0,  0,  0,  0, 0,  0,  0,  1,  1,   2,   3,   4,   5,   6,   7,   0, 0, 1, 0, 2'b00, 2'b00};
        tbl[12] = '{0,  0,  0,  1, 0,  0,  0,  0,  1,   2,   3,   4,   5,   6,   7,   0, 0, 1, 1, 2'b00, 2'b00};
        tbl[13] = '{0,  0,  1,  0, 0,  0,  0,  0,  3,   0,   1,   4,   0,   6,   7,   1, 1, 0, 1, 2'b00, 2'b00};
        tbl[14] = '{0,  0,  1,  1, 1,  0,  0,  0,  1,   5,   3,   4,   5,   6,   7,   1, 1, 1, 1, 2'b00, 2'b00};

        clear_inputs();
        Reset = 0;

        // Reset: stalls suppressed, forwarding still live, counter cleared.
        @(negedge clk);
        MemToRegE = 1; RA2D = 4'd5; WA3E = 4'd5; PCSrcD = 1;
        RegWriteM = 1; RA1E = 4'd3; WA3M = 4'd3;
        #1;
        chk("rst.StallF", StallF, 0);
        chk("rst.StallD", StallD, 0);
        chk("rst.FlushE", FlushE, 0);
        chk("rst.FlushD", FlushD, 0);
        chk("rst.McBusy", McBusy, 0);
        chk("rst.StallCnt", StallCnt, 0);
        chk("rst.ForwardAE", ForwardAE, 2'b10);

        @(negedge clk); clear_inputs(); Reset = 1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            RegWriteM = tbl[i].rwm; RegWriteW = tbl[i].rww; MemToRegE = tbl[i].m2r;
            BranchTakenE = tbl[i].bt; PCSrcD = tbl[i].pcd; PCSrcE = tbl[i].pce;
            PCSrcM = tbl[i].pcm; PCSrcW = tbl[i].pcw;
            RA1D = tbl[i].ra1d; RA2D = tbl[i].ra2d; RA1E = tbl[i].ra1e; RA2E = tbl[i].ra2e;
            WA3E = tbl[i].wa3e; WA3M = tbl[i].wa3m; WA3W = tbl[i].wa3w;
            #1;
            chk($sformatf("v%0d.StallF", i), StallF, tbl[i].sf);
            chk($sformatf("v%0d.StallD", i), StallD, tbl[i].sd);
            chk($sformatf("v%0d.FlushD", i), FlushD, tbl[i].fd);
            chk($sformatf("v%0d.FlushE", i), FlushE, tbl[i].fe);
            chk($sformatf("v%0d.ForwardAE", i), ForwardAE, tbl[i].fa);
            chk($sformatf("v%0d.ForwardBE", i), ForwardBE, tbl[i].fb);
            chk($sformatf("v%0d.StallE", i), StallE, 0);
            chk($sformatf("v%0d.FlushM", i), FlushM, 0);
        end

        // Address 0 hardwired on dut2 only.
        @(negedge clk); clear_inputs();
        MemToRegE = 1; WA3E = 4'd0; RA2D = 4'd0;
        RegWriteM = 1; WA3M = 4'd0; RA1E = 4'd0;
        #1;
        chk("r0.StallF_2", StallF_2, 0);
        chk("r0.StallD_2", StallD_2, 0);
        chk("r0.FlushE_2", FlushE_2, 0);
        chk("r0.ForwardAE_2", ForwardAE_2, 2'b00);
        chk("r0.StallF", StallF, 1);
        chk("r0.ForwardAE", ForwardAE, 2'b10);

        // Stall counter counts edges with StallF high.
        @(negedge clk); clear_inputs();
        do_reset();
        PCSrcD = 1;
        repeat (3) @(negedge clk);
        PCSrcD = 0; #1;
        chk("cnt.StallCnt3", StallCnt, 3);

`ifdef HAZARD_MC_EN
        // Multicycle op: start cycle in RUN, then 3 busy cycles, RUN on the 4th.
        @(negedge clk); clear_inputs(); McStartE = 1; #1;
        chk("mc.start.McBusy", McBusy, 0);
        chk("mc.start.StallE", StallE, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            McStartE = 1; MemToRegE = 1; RA2D = 4'd5; WA3E = 4'd5; PCSrcD = 1;
            #1;
            chk($sformatf("mc.b%0d.McBusy", k), McBusy, 1);
            chk($sformatf("mc.b%0d.StallF", k), StallF, 1);
            chk($sformatf("mc.b%0d.StallD", k), StallD, 1);
            chk($sformatf("mc.b%0d.StallE", k), StallE, 1);
            chk($sformatf("mc.b%0d.FlushM", k), FlushM, 1);
            chk($sformatf("mc.b%0d.FlushE", k), FlushE, 0);
            chk($sformatf("mc.b%0d.FlushD", k), FlushD, 0);
        end
        @(negedge clk); McStartE = 0; #1;
        chk("mc.end.McBusy", McBusy, 0);
        chk("mc.end.StallE", StallE, 0);
        chk("mc.end.FlushM", FlushM, 0);
        chk("mc.end.FlushE", FlushE, 1);

        // Branch wins over start.
        @(negedge clk); clear_inputs(); McStartE = 1; BranchTakenE = 1; #1;
        chk("br.FlushD", FlushD, 1);
        chk("br.FlushE", FlushE, 1);
        @(negedge clk); clear_inputs(); #1;
        chk("br.McBusy", McBusy, 0);
        chk("br.StallE", StallE, 0);

        // Reset during second busy cycle aborts the op.
        @(negedge clk); McStartE = 1;
        @(negedge clk); McStartE = 0; #1;
        chk("ra.b1.McBusy", McBusy, 1);
        @(negedge clk); #1;
        chk("ra.b2.McBusy", McBusy, 1);
        Reset = 0; #1;
        chk("ra.rst.McBusy", McBusy, 0);
        chk("ra.rst.StallF", StallF, 0);
        chk("ra.rst.StallCnt", StallCnt, 0);
        @(negedge clk); Reset = 1; #1;
        chk("ra.rel.McBusy", McBusy, 0);
        chk("ra.rel.StallE", StallE, 0);
        @(negedge clk); #1;
        chk("ra.rel2.McBusy", McBusy, 0);
        chk("ra.rel2.StallF", StallF, 0);
`else
        // Without the multicycle build McStartE has no effect.
        @(negedge clk); clear_inputs(); McStartE = 1; #1;
        chk("nomc.McBusy0", McBusy, 0);
        @(negedge clk); #1;
        chk("nomc.McBusy1", McBusy, 0);
        chk("nomc.StallE", StallE, 0);
        chk("nomc.FlushM", FlushM, 0);
        chk("nomc.StallF", StallF, 0);
`endif

        // Saturation: 20 stalled edges on a 4-bit counter.
        @(negedge clk); clear_inputs();
        do_reset();
        PCSrcD = 1;
        repeat (20) @(negedge clk);
        PCSrcD = 0; #1;
        chk("sat.StallCnt_2", StallCnt_2, 4'hF);
        chk("sat.StallCnt", StallCnt, 20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
